// File: rtl/spi_main_ctrl.sv
// SPI mode-0 initiator: one request becomes one framed transaction of a
// 5-bit command followed by a command-dependent payload.
module spi_main_ctrl #(
  parameter int unsigned HALF_DIV  = 4,
  parameter int unsigned CSB_SETUP = 4,
  parameter int unsigned CSB_HOLD  = 4,
  parameter int unsigned CSB_GAP   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [4:0]   req_cmd,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  output logic         rsp_err,
  output logic [127:0] rsp_rdata,
  output logic         sck,
  output logic         csb,
  output logic         mosi,
  input  logic         miso
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  localparam logic [7:0] HALF_LAST  = 8'(HALF_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CSB_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CSB_HOLD - 1);
  // The accepting IDLE cycle is the final csb-high cycle of the gap.
  localparam logic [7:0] GAP_LAST   = 8'(CSB_GAP - 2);

  state_t       state, state_nx;
  logic [7:0]   cnt, cnt_nx;
  logic         phase, phase_nx;
  logic [7:0]   bits, bits_nx;
  logic [7:0]   len, len_nx;
  logic         rd, rd_nx;
  logic [131:0] tx, tx_nx;
  logic [127:0] rx, rx_nx, rdata_nx;
  logic         sck_nx, csb_nx, mosi_nx, valid_nx, err_nx;
  logic [7:0]   dec_len;
  logic [127:0] dec_payload;

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    dec_len     = '0;
    dec_payload = '0;
    case (req_cmd[3:0])
      4'd0, 4'd1, 4'd2: begin
        dec_len     = 8'd128;
        dec_payload = req_wdata;
      end
      4'd3: begin
        dec_len     = 8'd3;
        dec_payload = {req_wdata[2:0], 125'b0};
      end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        dec_len     = 8'd64;
        dec_payload = {req_wdata[63:0], 64'b0};
      end
      default: ;
    endcase
    if (req_cmd[4]) dec_payload = '0;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    phase_nx = phase;
    bits_nx  = bits;
    len_nx   = len;
    rd_nx    = rd;
    tx_nx    = tx;
    rx_nx    = rx;
    rdata_nx = rsp_rdata;
    sck_nx   = sck;
    csb_nx   = csb;
    mosi_nx  = mosi;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (req_valid) begin
          if (dec_len == '0) begin
            valid_nx = 1'b1;
            err_nx   = 1'b1;
          end else begin
            state_nx = ST_SETUP;
            csb_nx   = 1'b0;
            rd_nx    = req_cmd[4];
            len_nx   = dec_len;
            bits_nx  = dec_len + 8'd4;
            tx_nx    = {req_cmd[3:0], dec_payload};
            mosi_nx  = req_cmd[4];
            rx_nx    = '0;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = ST_SHIFT;
          cnt_nx   = '0;
          phase_nx = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (!phase) begin
            phase_nx = 1'b1;
            sck_nx   = 1'b1;
          end else begin
            // bits counts remaining slots; below len means a payload slot
            if (rd && (bits < len)) rx_nx = {rx[126:0], miso};
            phase_nx = 1'b0;
            sck_nx   = 1'b0;
            if (bits == '0) begin
              state_nx = ST_HOLD;
            end else begin
              bits_nx = bits - 8'd1;
              tx_nx   = {tx[130:0], 1'b0};
              mosi_nx = tx[131];
            end
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = ST_GAP;
          cnt_nx   = '0;
          csb_nx   = 1'b1;
          mosi_nx  = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
          valid_nx = 1'b1;
          if (rd) rdata_nx = rx;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      bits      <= '0;
      len       <= '0;
      rd        <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      sck       <= 1'b0;
      csb       <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      phase     <= phase_nx;
      bits      <= bits_nx;
      len       <= len_nx;
      rd        <= rd_nx;
      tx        <= tx_nx;
      rx        <= rx_nx;
      rsp_rdata <= rdata_nx;
      rsp_valid <= valid_nx;
      rsp_err   <= err_nx;
      sck       <= sck_nx;
      csb       <= csb_nx;
      mosi      <= mosi_nx;
    end
  end

endmodule

// File: tb/tb_spi_main_ctrl.sv
// Directed bench for spi_main_ctrl: two controllers (default and HALF_DIV=2)
// each looped back to a small behavioural subnode.
module tb_spi_main_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_err, sck, csb, mosi, miso;
  logic [4:0]   req_cmd   [2];
  logic [127:0] req_wdata [2];
  logic [127:0] rsp_rdata [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_main_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd(req_cmd[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]), .sck(sck[0]), .csb(csb[0]),
    .mosi(mosi[0]), .miso(miso[0])
  );

  spi_main_ctrl #(.HALF_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd(req_cmd[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]), .sck(sck[1]), .csb(csb[1]),
    .mosi(mosi[1]), .miso(miso[1])
  );

  // Behavioural subnode: registers commit on csb rise after a complete write frame.
  logic [127:0] mem [2][9];
  logic [1:0]   op_ready, sck_d, csb_d;
  logic [132:0] rxsh [2];
  int           bitn [2];

  function automatic int tb_len(input logic [3:0] idx);
    if (idx <= 4'd2) return 128;
    if (idx == 4'd3) return 3;
    if (idx <= 4'd8) return 64;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : subnode
    logic [4:0] c;
    int n, k;
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        miso[u] <= 1'b1; sck_d[u] <= 1'b0; csb_d[u] <= 1'b1;
        op_ready[u] <= 1'b0; bitn[u] <= 0; rxsh[u] <= '0;
        for (int r = 0; r < 9; r++) mem[u][r] <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        sck_d[u] <= sck[u];
        csb_d[u] <= csb[u];
        if (csb[u]) begin
          bitn[u] <= 0;
          miso[u] <= 1'b1;
          if (!csb_d[u] && bitn[u] > 5) begin
            c = 5'(rxsh[u] >> (bitn[u] - 5));
            n = tb_len(c[3:0]);
            if (!c[4] && n != 0 && bitn[u] == 5 + n) begin
              mem[u][int'(c[3:0])] <= rxsh[u][127:0] & ((n == 128) ? {128{1'b1}} : ((128'd1 << n) - 128'd1));
              if (c[3:0] == 4'd3) op_ready[u] <= 1'b1;
            end
          end
        end else if (sck[u] && !sck_d[u]) begin
          rxsh[u] <= {rxsh[u][131:0], mosi[u]};
          bitn[u] <= bitn[u] + 1;
        end else if (!sck[u] && sck_d[u] && bitn[u] >= 5) begin
          c = 5'(rxsh[u] >> (bitn[u] - 5));
          n = tb_len(c[3:0]);
          k = n - 1 - (bitn[u] - 5);
          if (c[4] && n != 0 && k >= 0) miso[u] <= mem[u][int'(c[3:0])][k];
        end
      end
    end
  end

  // Free-running monitors, never reset.
  logic [1:0] mon_sck_d = '0;
  int rise_total [2] = '{0, 0};
  int rise_hi    [2] = '{0, 0};
  int csb_low    [2] = '{0, 0};
  int rsp_total  [2] = '{0, 0};
  int gap_run    [2] = '{0, 0};
  int last_gap   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      mon_sck_d[u] <= sck[u];
      if (sck[u] === 1'b1 && mon_sck_d[u] === 1'b0) rise_total[u] <= rise_total[u] + 1;
      if (sck[u] === 1'b1 && csb[u] === 1'b1) rise_hi[u] <= rise_hi[u] + 1;
      if (rsp_valid[u] === 1'b1) rsp_total[u] <= rsp_total[u] + 1;
      if (csb[u] === 1'b1) gap_run[u] <= gap_run[u] + 1;
      else begin
        csb_low[u] <= csb_low[u] + 1;
        if (gap_run[u] > 0) last_gap[u] <= gap_run[u];
        gap_run[u] <= 0;
      end
    end
  end

  task automatic do_req(input int u, input logic [4:0] cmd, input logic [127:0] wd,
                        output int lat, output int rises, output logic err, output logic [127:0] rd);
    int r0, n;
    @(negedge clk);
    req_cmd[u] = cmd; req_wdata[u] = wd; req_valid[u] = 1'b1;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    r0 = rise_total[u];
    @(negedge clk);
    req_valid[u] = 1'b0;
    lat = 1;
    while (rsp_valid[u] !== 1'b1 && lat < 5000) begin @(negedge clk); lat++; end
    err = rsp_err[u];
    rd  = rsp_rdata[u];
    @(negedge clk);
    rises = rise_total[u] - r0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[0]); end
    checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err[0]); end
    checks++; if (rsp_rdata[0] !== 128'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata[0]); end
    checks++; if (sck !== 2'b00) begin errors++; $display("FAIL reset_sck got %b want 00", sck); end
    checks++; if (csb !== 2'b11) begin errors++; $display("FAIL reset_csb got %b want 11", csb); end
    checks++; if (mosi !== 2'b00) begin errors++; $display("FAIL reset_mosi got %b want 00", mosi); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write128();
    int lat, rises; logic err; logic [127:0] rd;
    do_req(0, 5'h00, 128'h0123456789ABCDEF_FEDCBA9876543210, lat, rises, err, rd);
    checks++; if (lat != 1076) begin errors++; $display("FAIL w128_latency got %0d want 1076", lat); end
    checks++; if (rises != 133) begin errors++; $display("FAIL w128_sck_rises got %0d want 133", rises); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL w128_err got %b want 0", err); end
    checks++; if (rd !== 128'h0) begin errors++; $display("FAIL w128_rdata_held got %h want 0", rd); end
    checks++; if (mem[0][0] !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
      errors++; $display("FAIL w128_reg0 got %h want 0123456789abcdeffedcba9876543210", mem[0][0]); end
  endtask

  task automatic test_rw64();
    int lat, rises; logic err; logic [127:0] rd;
    do_req(0, 5'h06, 128'hDEADBEEF_CAFEF00D, lat, rises, err, rd);
    checks++; if (lat != 564) begin errors++; $display("FAIL w64_latency got %0d want 564", lat); end
    checks++; if (rises != 69) begin errors++; $display("FAIL w64_sck_rises got %0d want 69", rises); end
    checks++; if (mem[0][6] !== 128'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL w64_reg6 got %h want deadbeefcafef00d", mem[0][6]); end
    do_req(0, 5'h16, 128'h0, lat, rises, err, rd);
    checks++; if (rises != 69) begin errors++; $display("FAIL r64_sck_rises got %0d want 69", rises); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL r64_err got %b want 0", err); end
    checks++; if (rd !== 128'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL r64_rdata got %h want deadbeefcafef00d", rd); end
  endtask

  task automatic test_opmode();
    int lat, rises; logic err; logic [127:0] rd;
    do_req(0, 5'h03, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFD, lat, rises, err, rd);
    checks++; if (lat != 76) begin errors++; $display("FAIL wop_latency got %0d want 76", lat); end
    checks++; if (rises != 8) begin errors++; $display("FAIL wop_sck_rises got %0d want 8", rises); end
    checks++; if (mem[0][3] !== 128'h5) begin errors++; $display("FAIL wop_mode got %h want 5", mem[0][3]); end
    checks++; if (op_ready[0] !== 1'b1) begin errors++; $display("FAIL wop_ready got %b want 1", op_ready[0]); end
    do_req(0, 5'h13, 128'h0, lat, rises, err, rd);
    checks++; if (rd !== 128'h5) begin errors++; $display("FAIL rop_rdata got %h want 5", rd); end
  endtask

  task automatic test_illegal();
    int r0, c0;
    r0 = rise_total[0]; c0 = csb_low[0];
    @(negedge clk);
    req_cmd[0] = 5'h09; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL ill_valid got %b want 1", rsp_valid[0]); end
    checks++; if (rsp_err[0] !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", rsp_err[0]); end
    checks++; if (rsp_rdata[0] !== 128'h5) begin errors++; $display("FAIL ill_rdata_held got %h want 5", rsp_rdata[0]); end
    @(negedge clk);
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL ill_pulse got %b want 0", rsp_valid[0]); end
    repeat (20) @(negedge clk);
    checks++; if (csb_low[0] != c0) begin errors++; $display("FAIL ill_csb_low got %0d want %0d", csb_low[0], c0); end
    checks++; if (rise_total[0] != r0) begin errors++; $display("FAIL ill_sck_rises got %0d want %0d", rise_total[0], r0); end
  endtask

  task automatic test_abort();
    int r0, n, p0, lat, rises; logic err; logic [127:0] rd;
    @(negedge clk);
    req_cmd[0] = 5'h00; req_wdata[0] = {4{32'hA5A5_5A5A}}; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    r0 = rise_total[0];
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rise_total[0] - r0 < 46 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n >= 3000) begin errors++; $display("FAIL abort_reach_slot got %0d rises want 46", rise_total[0] - r0); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (csb[0] !== 1'b1) begin errors++; $display("FAIL abort_csb got %b want 1", csb[0]); end
    checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL abort_sck got %b want 0", sck[0]); end
    checks++; if (mosi[0] !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b want 0", mosi[0]); end
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready[0]); end
    checks++; if (rsp_rdata[0] !== 128'h0) begin errors++; $display("FAIL abort_rdata got %h want 0", rsp_rdata[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = rsp_total[0];
    repeat (1200) @(negedge clk);
    checks++; if (rsp_total[0] != p0) begin errors++; $display("FAIL abort_no_rsp got %0d want %0d", rsp_total[0], p0); end
    do_req(0, 5'h10, 128'h0, lat, rises, err, rd);
    checks++; if (lat != 1076) begin errors++; $display("FAIL abort_rd_latency got %0d want 1076", lat); end
    checks++; if (rd !== 128'h0) begin errors++; $display("FAIL abort_rd_reg0 got %h want 0", rd); end
  endtask

  task automatic test_back_to_back(input int u, input logic [4:0] cmd, input logic [63:0] wd, input int exp_lat);
    int r0, n;
    @(negedge clk);
    req_cmd[u] = cmd; req_wdata[u] = {64'h0, wd}; req_valid[u] = 1'b1;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    r0 = rise_total[u];
    @(negedge clk);
    req_cmd[u] = cmd | 5'h10;
    n = 1;
    while (rsp_valid[u] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (n != exp_lat) begin errors++; $display("FAIL b2b%0d_wr_latency got %0d want %0d", u, n, exp_lat); end
    checks++; if (req_ready[u] !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready_at_rsp got %b want 1", u, req_ready[u]); end
    @(negedge clk);
    req_valid[u] = 1'b0;
    checks++; if (csb[u] !== 1'b0) begin errors++; $display("FAIL b2b%0d_csb_restart got %b want 0", u, csb[u]); end
    n = 1;
    while (rsp_valid[u] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (n != exp_lat) begin errors++; $display("FAIL b2b%0d_rd_latency got %0d want %0d", u, n, exp_lat); end
    checks++; if (rsp_rdata[u] !== {64'h0, wd}) begin errors++; $display("FAIL b2b%0d_rdata got %h want %h", u, rsp_rdata[u], {64'h0, wd}); end
    checks++; if (last_gap[u] != 4) begin errors++; $display("FAIL b2b%0d_gap got %0d want 4", u, last_gap[u]); end
    @(negedge clk);
    checks++; if (rise_total[u] - r0 != 138) begin errors++; $display("FAIL b2b%0d_sck_rises got %0d want 138", u, rise_total[u] - r0); end
    checks++; if (rise_hi[u] != 0) begin errors++; $display("FAIL b2b%0d_rise_csb_high got %0d want 0", u, rise_hi[u]); end
  endtask

  initial begin
    req_valid = '0;
    for (int u = 0; u < 2; u++) begin
      req_cmd[u] = '0;
      req_wdata[u] = '0;
    end
    test_reset();
    test_write128();
    test_rw64();
    test_opmode();
    test_illegal();
    test_abort();
    test_back_to_back(0, 5'h07, 64'h0123_4567_89AB_CDEF, 564);
    test_back_to_back(1, 5'h08, 64'hF0E1_D2C3_B4A5_9687, 288);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
